// File: rtl/ram_burst_master.sv
// ---------------------------------------------------------------------------
// ram_burst_master
//
// Turns burst commands into per-cycle strobes on one port of a dual-port RAM
// that has a registered read (data valid one cycle after ram_re). Write bursts
// stream wr_data beats into consecutive addresses. Read bursts stream RAM
// words out through a two-entry, backpressured read buffer.
//
// Ports
//   clk, reset            : single clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_write             : 1 = write burst, 0 = read burst
//   cmd_addr              : burst start address
//   cmd_len               : beats minus one
//   wr_valid/wr_ready     : write beat handshake
//   wr_data               : write beat data
//   rd_valid/rd_ready     : read beat handshake
//   rd_data               : read beat data (head of the read buffer)
//   busy                  : burst active, read in flight or buffer non-empty
//   ram_we/ram_re         : RAM write / read strobes
//   ram_addr, ram_din     : RAM address and write data
//   ram_dout              : RAM read data, valid the cycle after ram_re
// ---------------------------------------------------------------------------
module ram_burst_master #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    logic                  w_pop;
    logic [2:0]            w_occupancy;
    logic                  w_creditOk;
    logic                  w_issue;
    logic                  w_writeBeat;
    logic                  w_advance;

    assign rd_valid    = (r_count != 2'd0);
    assign w_pop       = rd_valid && rd_ready;

    // Buffered words plus the one still coming back from the RAM must never
    // exceed the buffer depth, counting the slot freed by a pop this cycle.
    // A pop implies r_count >= 1, so the subtraction cannot underflow.
    assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
    assign w_creditOk  = (w_occupancy - {2'b00, w_pop}) < 3'd2;

    assign w_issue     = (r_state == ST_READ) && w_creditOk;
    assign w_writeBeat = (r_state == ST_WRITE) && wr_valid;
    assign w_advance   = w_issue || w_writeBeat;

    assign cmd_ready   = (r_state == ST_IDLE);
    assign wr_ready    = (r_state == ST_WRITE);
    assign ram_we      = w_writeBeat;
    assign ram_re      = w_issue;
    assign ram_addr    = r_addr;
    assign ram_din     = (r_state == ST_WRITE) ? wr_data : '0;
    // Gate the head with rd_valid so an empty buffer shows zero, not stale data.
    assign rd_data     = rd_valid ? r_mem[r_rptr] : '0;
    assign busy        = (r_state != ST_IDLE) || r_inflight || rd_valid;

    // Command/burst sequencing: address and beat counters advance once per
    // accepted write beat or issued read; the last beat returns to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= cmd_addr;
                        r_remaining <= cmd_len;
                        r_state     <= cmd_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (w_advance) begin
                        r_addr      <= r_addr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (r_remaining == '0) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read return path: a read issued this cycle lands on ram_dout next cycle
    // and is pushed into the two-entry buffer; clearing r_inflight on reset
    // is what discards the word returning right after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_mem[r_wptr] <= ram_dout;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// ---------------------------------------------------------------------------
// tb_ram_burst_master
//
// Directed bench for ram_burst_master. A small behavioural RAM with a
// registered read sits on the RAM port; a negedge monitor records every write
// strobe, read issue and read pop, and tracks strobe overlap, read credit and
// stall stability. All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ram_burst_master;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] rd_data;
    logic       busy;
    logic       ram_we;
    logic       ram_re;
    logic [3:0] ram_addr;
    logic [3:0] ram_din;
    logic [3:0] ram_dout;

    int compareCount;
    int mismatchCount;

    logic [3:0] ramMem [16];

    logic [3:0] wrAddrQ [$];
    logic [3:0] wrDataQ [$];
    logic [3:0] rdAddrQ [$];
    logic [3:0] popQ    [$];
    int         issuedCount;
    int         poppedCount;
    int         bothStrobeErr;
    int         creditErr;
    int         stallErr;
    logic       prevStall;
    logic [3:0] prevData;

    ram_burst_master #(
        .DATA_WIDTH(4),
        .ADDR_WIDTH(4),
        .LEN_WIDTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .busy     (busy),
        .ram_we   (ram_we),
        .ram_re   (ram_re),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM port: write-on-we, registered read with one-cycle latency.
    initial begin
        for (int i = 0; i < 16; i++) ramMem[i] = 4'h0;
        ram_dout = 4'h0;
    end

    always @(posedge clk) begin
        if (ram_we) ramMem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= ramMem[ram_addr];
    end

    // Monitor on the falling edge: everything sampled here is what the DUT
    // will act on at the next rising edge.
    initial begin
        issuedCount   = 0;
        poppedCount   = 0;
        bothStrobeErr = 0;
        creditErr     = 0;
        stallErr      = 0;
        prevStall     = 1'b0;
        prevData      = 4'h0;
    end

    always @(negedge clk) begin
        if (reset) begin
            poppedCount = issuedCount;
            prevStall   = 1'b0;
        end else begin
            if (ram_we && ram_re) bothStrobeErr++;
            if (ram_we) begin
                wrAddrQ.push_back(ram_addr);
                wrDataQ.push_back(ram_din);
            end
            if (ram_re) begin
                rdAddrQ.push_back(ram_addr);
                issuedCount++;
            end
            if (prevStall && (!rd_valid || rd_data !== prevData)) stallErr++;
            if (rd_valid && rd_ready) begin
                popQ.push_back(rd_data);
                poppedCount++;
            end
            if (issuedCount - poppedCount > 2) creditErr++;
            prevStall = rd_valid && !rd_ready;
            prevData  = rd_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command and hold it for exactly one accepting cycle.
    task automatic applyStimulus(input logic write, input logic [3:0] addr,
                                 input logic [3:0] len, input string tag);
        cmd_valid = 1'b1;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_len   = len;
        #1;
        checkOutput($sformatf("%s cmdReady", tag), cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " cmd_ready"}, cmd_ready, 1);
        checkOutput({tag, " wr_ready"},  wr_ready,  0);
        checkOutput({tag, " rd_valid"},  rd_valid,  0);
        checkOutput({tag, " rd_data"},   rd_data,   0);
        checkOutput({tag, " busy"},      busy,      0);
        checkOutput({tag, " ram_we"},    ram_we,    0);
        checkOutput({tag, " ram_re"},    ram_re,    0);
        checkOutput({tag, " ram_addr"},  ram_addr,  0);
        checkOutput({tag, " ram_din"},   ram_din,   0);
    endtask

    // Write burst; gapPat bit k gives wr_valid in cycle k (patLen 0 = continuous).
    task automatic doWrite(input logic [3:0] addr, input logic [3:0] len,
                           input logic [63:0] dataPacked, input logic [15:0] gapPat,
                           input int patLen, input string tag);
        int idx;
        logic v;
        idx = 0;
        applyStimulus(1'b1, addr, len, tag);
        for (int cyc = 0; cyc < 40 && idx <= int'(len); cyc++) begin
            v = (patLen == 0) ? 1'b1 : gapPat[cyc % patLen];
            wr_valid = v;
            wr_data  = v ? dataPacked[4*idx +: 4] : 4'hF;
            step();
            if (v) idx++;
        end
        wr_valid = 1'b0;
        wr_data  = 4'h0;
        #1;
        checkOutput($sformatf("%s cmdReadyAfter", tag), cmd_ready, 1);
    endtask

    // Read burst; rdyPat bit k gives rd_ready in cycle k (patLen 0 = always ready).
    task automatic doRead(input logic [3:0] addr, input logic [3:0] len,
                          input logic [15:0] rdyPat, input int patLen, input string tag);
        int base;
        base = popQ.size();
        applyStimulus(1'b0, addr, len, tag);
        for (int cyc = 0; cyc < 80 && (popQ.size() - base) <= int'(len); cyc++) begin
            rd_ready = (patLen == 0) ? 1'b1 : rdyPat[cyc % patLen];
            step();
        end
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && busy; cyc++) step();
        checkOutput($sformatf("%s idle", tag), busy, 0);
    endtask

    task automatic checkWrites(input string tag, input int base, input int n,
                               input logic [63:0] addrs, input logic [63:0] data);
        checkOutput({tag, " nWrites"}, wrAddrQ.size() - base, n);
        for (int i = 0; i < n && base + i < wrAddrQ.size(); i++) begin
            checkOutput($sformatf("%s wAddr%0d", tag, i), wrAddrQ[base+i], addrs[4*i +: 4]);
            checkOutput($sformatf("%s wData%0d", tag, i), wrDataQ[base+i], data[4*i +: 4]);
        end
    endtask

    task automatic checkReads(input string tag, input int rBase, input int pBase, input int n,
                              input logic [63:0] addrs, input logic [63:0] data);
        checkOutput({tag, " nIssues"}, rdAddrQ.size() - rBase, n);
        checkOutput({tag, " nPops"},   popQ.size() - pBase,    n);
        for (int i = 0; i < n && rBase + i < rdAddrQ.size(); i++)
            checkOutput($sformatf("%s rAddr%0d", tag, i), rdAddrQ[rBase+i], addrs[4*i +: 4]);
        for (int i = 0; i < n && pBase + i < popQ.size(); i++)
            checkOutput($sformatf("%s rData%0d", tag, i), popQ[pBase+i], data[4*i +: 4]);
    endtask

    // Per-cycle expectations for the back-to-back read of A,B,C,D at 3..6,
    // cycles 1..7 after the command handshake.
    logic       t2Re    [7] = '{1, 1, 1, 1, 0, 0, 0};
    logic [3:0] t2Addr  [7] = '{3, 4, 5, 6, 7, 7, 7};
    logic       t2Valid [7] = '{0, 0, 1, 1, 1, 1, 0};
    logic [3:0] t2Data  [7] = '{0, 0, 4'hA, 4'hB, 4'hC, 4'hD, 0};
    logic       t2Busy  [7] = '{1, 1, 1, 1, 1, 1, 0};

    initial begin
        int wBase;
        int rBase;
        int pBase;
        compareCount  = 0;
        mismatchCount = 0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_len   = 4'h0;
        wr_valid  = 1'b0;
        wr_data   = 4'h0;
        rd_ready  = 1'b1;

        #1 reset = 1'b1;
        #2;
        checkResetOutputs("reset");
        step();
        step();
        reset = 1'b0;
        step();

        $display("[TB] write burst addr 3 len 3");
        wBase = wrAddrQ.size();
        doWrite(4'd3, 4'd3, 64'hDCBA, 16'h0, 0, "t1");
        checkWrites("t1", wBase, 4, 64'h6543, 64'hDCBA);

        $display("[TB] read burst addr 3 len 3, always ready");
        pBase = popQ.size();
        rd_ready = 1'b1;
        applyStimulus(1'b0, 4'd3, 4'd3, "t2");
        for (int c = 0; c < 7; c++) begin
            #1;
            checkOutput($sformatf("t2 c%0d ram_re", c + 1), ram_re, t2Re[c]);
            if (t2Re[c])
                checkOutput($sformatf("t2 c%0d ram_addr", c + 1), ram_addr, t2Addr[c]);
            checkOutput($sformatf("t2 c%0d rd_valid", c + 1), rd_valid, t2Valid[c]);
            if (t2Valid[c])
                checkOutput($sformatf("t2 c%0d rd_data", c + 1), rd_data, t2Data[c]);
            checkOutput($sformatf("t2 c%0d busy", c + 1), busy, t2Busy[c]);
            step();
        end
        checkOutput("t2 nPops", popQ.size() - pBase, 4);

        $display("[TB] write addr 0 len 7, read back with rd_ready 1,0,0,1");
        wBase = wrAddrQ.size();
        doWrite(4'd0, 4'd7, 64'h8C17E295, 16'h0, 0, "t3w");
        checkWrites("t3w", wBase, 8, 64'h76543210, 64'h8C17E295);
        rBase = rdAddrQ.size();
        pBase = popQ.size();
        doRead(4'd0, 4'd7, 16'h9, 4, "t3r");
        checkReads("t3r", rBase, pBase, 8, 64'h76543210, 64'h8C17E295);

        $display("[TB] wrapping write and read at addr 14");
        wBase = wrAddrQ.size();
        doWrite(4'd14, 4'd3, 64'h4321, 16'h0, 0, "t4w");
        checkWrites("t4w", wBase, 4, 64'h10FE, 64'h4321);
        rBase = rdAddrQ.size();
        pBase = popQ.size();
        doRead(4'd14, 4'd3, 16'h0, 0, "t4r");
        checkReads("t4r", rBase, pBase, 4, 64'h10FE, 64'h4321);

        $display("[TB] write with wr_valid gaps 1,0,1,1,0,1");
        wBase = wrAddrQ.size();
        doWrite(4'd8, 4'd3, 64'h9876, 16'h002D, 6, "t5");
        checkWrites("t5", wBase, 4, 64'hBA98, 64'h9876);

        $display("[TB] reset during third beat of an 8-beat read");
        rd_ready = 1'b1;
        applyStimulus(1'b0, 4'd0, 4'd7, "t6");
        step();
        step();
        reset = 1'b1;
        #1;
        checkResetOutputs("t6 inReset");
        step();
        step();
        reset = 1'b0;
        #1;
        checkOutput("t6 rdValidAfterRelease", rd_valid, 0);
        pBase = popQ.size();
        applyStimulus(1'b0, 4'd5, 4'd0, "t6new");
        #1;
        checkOutput("t6new c1 ram_re", ram_re, 1);
        checkOutput("t6new c1 ram_addr", ram_addr, 5);
        checkOutput("t6new c1 rd_valid", rd_valid, 0);
        step();
        #1;
        checkOutput("t6new c2 rd_valid", rd_valid, 0);
        step();
        #1;
        checkOutput("t6new c3 rd_valid", rd_valid, 1);
        checkOutput("t6new c3 rd_data", rd_data, 1);
        step();
        #1;
        checkOutput("t6new nPops", popQ.size() - pBase, 1);
        checkOutput("t6new busy", busy, 0);

        checkOutput("weReOverlap", bothStrobeErr, 0);
        checkOutput("readCredit", creditErr, 0);
        checkOutput("stallStable", stallErr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
